// File: rtl/vga_tile_fb.sv
// Tile framebuffer for an 800x600 raster: one bit per 8x8 tile, host writes through
// a valid/ready port, a clear FSM zeroes the store, and a two-stage read pipeline produces colour.
module vga_tile_fb #(
  parameter int          TILE_W     = 100,
  parameter int          TILE_H     = 75,
  parameter int          TILE_SHIFT = 3,
  parameter logic [2:0]  FG_COLOR   = 3'b111,
  parameter logic [2:0]  BG_COLOR   = 3'b000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [9:0] x_coord,
  input  logic [9:0] y_coord,
  input  logic       blank_in,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_x,
  input  logic [6:0] wr_y,
  input  logic       wr_data,
  input  logic       clear_req,
  output logic       clear_busy,
  output logic [2:0] color_out,
  output logic       blank_out
);

  localparam int             N         = TILE_W * TILE_H;
  localparam int             AW        = $clog2(N);
  localparam logic [9:0]     TW_C      = 10'(TILE_W);
  localparam logic [9:0]     TH_C      = 10'(TILE_H);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(N - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clear_addr_q, clear_addr_d;

  logic            store_mem [N];

  logic [9:0]      tx_c, ty_c;
  logic [9:0]      tx_p0, ty_p0;
  logic            in_range_p0, blank_p0, vld_p0;
  logic [AW-1:0]   rd_addr;
  logic            rd_bit;

  logic            wr_fire, wr_in_range;
  logic [AW-1:0]   wr_addr;

  // Clear FSM: state register plus registered status outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= CLEAR;
      clear_addr_q <= '0;
      clear_busy   <= 1'b1;
      wr_ready     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      clear_busy   <= (state_d == CLEAR);
      wr_ready     <= (state_d == IDLE);
    end
  end

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    case (state_q)
      CLEAR: begin
        clear_addr_d = clear_addr_q + 1'b1;
        if (clear_addr_q == LAST_ADDR) begin
          state_d      = IDLE;
          clear_addr_d = '0;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d      = CLEAR;
          clear_addr_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Host writes outside the tile grid complete the handshake but never touch the store
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = ({3'b000, wr_x} < TW_C) && ({3'b000, wr_y} < TH_C);
  assign wr_addr     = AW'(32'(wr_y) * TILE_W + 32'(wr_x));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      if (state_q == CLEAR)
        store_mem[clear_addr_q] <= 1'b0;
      else if (wr_fire && wr_in_range)
        store_mem[wr_addr] <= wr_data;
    end
  end

  // Stage 1: tile coordinates, range flag and blank
  assign tx_c = x_coord >> TILE_SHIFT;
  assign ty_c = y_coord >> TILE_SHIFT;

  always_ff @(posedge sys_clk) begin
    tx_p0       <= tx_c;
    ty_p0       <= ty_c;
    in_range_p0 <= (tx_c < TW_C) && (ty_c < TH_C);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_p0   <= 1'b0;
      blank_p0 <= 1'b1;
    end else begin
      vld_p0   <= 1'b1;
      blank_p0 <= blank_in;
    end
  end

  // Stage 2: store lookup; a same-edge write is seen only by the following read
  assign rd_addr = in_range_p0 ? AW'(32'(ty_p0) * TILE_W + 32'(tx_p0)) : '0;
  assign rd_bit  = store_mem[rd_addr];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      color_out <= BG_COLOR;
      blank_out <= 1'b1;
    end else begin
      color_out <= (vld_p0 && rd_bit && in_range_p0 && !blank_p0 && (state_q == IDLE))
                   ? FG_COLOR : BG_COLOR;
      blank_out <= blank_p0;
    end
  end

endmodule

// File: tb/tb_vga_tile_fb.sv
// Directed bench for vga_tile_fb: expected pixels queued at drive time, popped when output is due.
module tb_vga_tile_fb;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [9:0] x_coord, y_coord;
  logic       blank_in;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_x, wr_y;
  logic       wr_data;
  logic       clear_req;
  logic       clear_busy;
  logic [2:0] color_out;
  logic       blank_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] color;
    logic       blank;
    string      tag;
  } exp_t;

  exp_t sb[$];

  vga_tile_fb dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .x_coord    (x_coord),
    .y_coord    (y_coord),
    .blank_in   (blank_in),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .color_out  (color_out),
    .blank_out  (blank_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, "_color"}, int'(color_out), int'(e.color));
    chk({e.tag, "_blank"}, int'(blank_out), int'(e.blank));
  endtask

  // One pixel per cycle; the entry pushed one drive earlier is due after this edge
  task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic b,
                       input logic [2:0] ec, input logic eb, input string tag);
    exp_t e;
    x_coord  = x;
    y_coord  = y;
    blank_in = b;
    e.color  = ec;
    e.blank  = eb;
    e.tag    = tag;
    sb.push_back(e);
    tick();
    if (sb.size() >= 2) pop_check();
  endtask

  task automatic flush();
    while (sb.size() > 0) begin
      tick();
      pop_check();
    end
  endtask

  task automatic wr_tile(input logic [6:0] tx, input logic [6:0] ty, input logic d,
                         input string tag);
    wr_x     = tx;
    wr_y     = ty;
    wr_data  = d;
    wr_valid = 1'b1;
    chk({tag, "_ready"}, int'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_ready(input int start, output int n);
    n = start;
    while (wr_ready !== 1'b1 && n < 20000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    sys_rst   = 1'b1;
    x_coord   = 10'd24;
    y_coord   = 10'd16;
    blank_in  = 1'b0;
    wr_valid  = 1'b0;
    wr_x      = '0;
    wr_y      = '0;
    wr_data   = 1'b0;
    clear_req = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy",  int'(clear_busy), 1);
    chk("rst_ready", int'(wr_ready),   0);
    chk("rst_color", int'(color_out),  0);
    chk("rst_blank", int'(blank_out),  1);

    // Initial clear, with a clear_req pulse inside it that must be ignored
    sys_rst = 1'b0;
    repeat (5) tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (4) tick();
    wait_ready(10, n);
    chk("init_clear_len", n, 7500);
    chk("init_busy_low",  int'(clear_busy), 0);

    // Set tile (3,2) and read around it, including blanking and back-to-back pixels
    wr_tile(7'd3, 7'd2, 1'b1, "wr32");
    drive(10'd24,  10'd16,  1'b0, 3'b111, 1'b0, "t32_hit");
    drive(10'd23,  10'd16,  1'b0, 3'b000, 1'b0, "t22_miss");
    drive(10'd31,  10'd23,  1'b0, 3'b111, 1'b0, "t32_corner");
    drive(10'd24,  10'd16,  1'b1, 3'b000, 1'b1, "t32_blanked");
    drive(10'h3FF, 10'h3FF, 1'b1, 3'b000, 1'b1, "offscreen");
    flush();

    // Out-of-range write completes and must not alias onto tile (0,1)
    wr_tile(7'd100, 7'd0, 1'b1, "wr100");
    drive(10'd799, 10'd0, 1'b0, 3'b000, 1'b0, "t99_0");
    drive(10'd0,   10'd8, 1'b0, 3'b000, 1'b0, "t0_1");
    flush();

    // Read and write of the same tile on the same edge: old data, then new
    drive(10'd56, 10'd56, 1'b0, 3'b000, 1'b0, "rdw_old");
    wr_x = 7'd7; wr_y = 7'd7; wr_data = 1'b1; wr_valid = 1'b1;
    drive(10'd56, 10'd56, 1'b0, 3'b111, 1'b0, "rdw_new");
    wr_valid = 1'b0;
    flush();

    // Tile (6,6) set, then write (5,5) together with clear_req; output forced off during clear
    wr_tile(7'd6, 7'd6, 1'b1, "wr66");
    drive(10'd48, 10'd48, 1'b0, 3'b111, 1'b0, "t66_set");
    flush();
    wr_x = 7'd5; wr_y = 7'd5; wr_data = 1'b1; wr_valid = 1'b1; clear_req = 1'b1;
    chk("wr55_ready", int'(wr_ready), 1);
    tick();
    wr_valid = 1'b0; clear_req = 1'b0;
    chk("clr_ready_low", int'(wr_ready),   0);
    chk("clr_busy_high", int'(clear_busy), 1);
    drive(10'd48, 10'd48, 1'b0, 3'b000, 1'b0, "t66_in_clear");
    flush();
    wait_ready(2, n);
    chk("clr_len", n, 7500);
    drive(10'd40, 10'd40, 1'b0, 3'b000, 1'b0, "t55_cleared");
    drive(10'd48, 10'd48, 1'b0, 3'b000, 1'b0, "t66_cleared");
    flush();

    // Reset partway through a clear restarts it from address 0
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (1000) tick();
    chk("mid_busy", int'(clear_busy), 1);
    sys_rst = 1'b1;
    tick();
    chk("mid_rst_busy",  int'(clear_busy), 1);
    chk("mid_rst_ready", int'(wr_ready),   0);
    chk("mid_rst_color", int'(color_out),  0);
    chk("mid_rst_blank", int'(blank_out),  1);
    sys_rst = 1'b0;
    wait_ready(0, n);
    chk("rst_clear_len", n, 7500);
    chk("rst_busy_low",  int'(clear_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
